// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues req/ack fetches to instruction
// memory, and buffers prefetched instructions in a small FIFO feeding decode.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redir_valid,
  input  logic [1:0]             redir_mode,
  input  logic [XLEN-1:0]        redir_pc,
  input  logic [25:0]            redir_imm,
  input  logic [XLEN-1:0]        redir_reg,
  output logic                   ins_valid,
  input  logic                   ins_ready,
  output logic [31:0]            ins_data,
  output logic [XLEN-1:0]        ins_pc,
  output logic [XLEN-1:0]        ins_pc4,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   misalign
);

  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam int unsigned     CW   = AW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [1:0] {
    MODE_BRANCH = 2'b00,
    MODE_JUMP   = 2'b01,
    MODE_JR     = 2'b10,
    MODE_RESYNC = 2'b11
  } redir_mode_e;

  redir_mode_e     mode;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] redir_pc4;
  logic [XLEN-1:0] branch_off;
  logic [XLEN-1:0] redir_target;
  logic            drop;
  logic            ack;
  logic            enq;
  logic            pop;
  logic            issue;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic [31:0]     data_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] pc4_mem  [DEPTH];

  assign mode = redir_mode_e'(redir_mode);

  always_comb begin
    redir_pc4    = redir_pc + FOUR;
    branch_off   = {{(XLEN-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};
    redir_target = redir_pc4;
    case (mode)
      MODE_BRANCH: redir_target = redir_pc4 + branch_off;
      MODE_JUMP:   redir_target = {redir_pc4[XLEN-1:28], redir_imm, 2'b00};
      MODE_JR:     redir_target = {redir_reg[XLEN-1:2], 2'b00};
      default:     redir_target = redir_pc4;
    endcase
  end

  // A dropped (stale) ack neither enqueues nor advances the PC; a redirect
  // empties the queue, so the credit check after it always sees room.
  always_comb begin
    ack   = imem_req & imem_ack;
    pop   = ins_valid & ins_ready;
    enq   = ack & ~drop & ~redir_valid;
    fetch_pc_next = fetch_pc;
    if (redir_valid)
      fetch_pc_next = redir_target;
    else if (ack && !drop)
      fetch_pc_next = fetch_pc + FOUR;
    count_next = redir_valid ? '0 : count + CW'(enq) - CW'(pop);
    issue      = (~imem_req | ack) & (count_next < FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      drop      <= 1'b0;
      misalign  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
    end else begin
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      if (issue) begin
        imem_req  <= 1'b1;
        imem_addr <= fetch_pc_next;
      end else if (ack) begin
        imem_req <= 1'b0;
      end
      if (ack)
        drop <= 1'b0;
      else if (redir_valid && imem_req)
        drop <= 1'b1;
      misalign <= redir_valid & (mode == MODE_JR) & (|redir_reg[1:0]);
      if (redir_valid) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (enq)
          wptr <= wptr + AW'(1);
        if (pop)
          rptr <= rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem[wptr] <= imem_rdata;
      pc_mem[wptr]   <= fetch_pc;
      pc4_mem[wptr]  <= fetch_pc + FOUR;
    end
  end

  // Head fields are forced to zero while empty so flushed or reset state never leaks out.
  assign ins_valid = (count != '0);
  assign ins_data  = ins_valid ? data_mem[rptr] : '0;
  assign ins_pc    = ins_valid ? pc_mem[rptr]   : '0;
  assign ins_pc4   = ins_valid ? pc4_mem[rptr]  : '0;
  assign q_count   = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with programmable wait states plus a
// scoreboard of fetched PCs, redirect vector table and hand-written corner cases.
`timescale 1ns/1ps

module tb_fetch_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] MASK     = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [1:0]  redir_mode;
  logic [31:0] redir_pc;
  logic [25:0] redir_imm;
  logic [31:0] redir_reg;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic [31:0] ins_pc4;
  logic [2:0]  q_count;
  logic        misalign;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_mode(redir_mode), .redir_pc(redir_pc),
    .redir_imm(redir_imm), .redir_reg(redir_reg),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .ins_pc(ins_pc), .ins_pc4(ins_pc4), .q_count(q_count), .misalign(misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] pc;
    logic [25:0] imm;
    logic [31:0] rreg;
    logic [31:0] target;
    logic        mis;
  } redir_vec_t;

  redir_vec_t  vecs [8];
  int          assert_count = 0;
  int          fail_count   = 0;
  logic [31:0] sb_pc_q [$];
  logic        discard_pending;
  logic [31:0] exp_next_addr;
  logic [31:0] tb_target;
  int          mem_waits;
  int          wait_cnt;
  int          ack_count;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;

  task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Memory responder and scoreboard, evaluated on the falling edge.
  initial begin
    imem_ack = 1'b0;
    imem_rdata = '0;
    discard_pending = 1'b0;
    exp_next_addr = RESET_PC;
    wait_cnt = 0;
    ack_count = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        imem_ack = 1'b0;
        sb_pc_q.delete();
        discard_pending = 1'b0;
        exp_next_addr = RESET_PC;
        wait_cnt = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        continue;
      end
      if (prev_req && prev_ack) begin
        ack_count++;
        if (discard_pending) begin
          discard_pending = 1'b0;
        end else begin
          sb_pc_q.push_back(prev_addr);
          exp_next_addr = prev_addr + 32'd4;
        end
      end else if (prev_req) begin
        checkOutput("req_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
      end
      if (imem_req && (!prev_req || prev_ack)) begin
        checkOutput("req_addr", imem_addr, exp_next_addr);
        wait_cnt = 0;
      end
      checkOutput("q_count", q_count, sb_pc_q.size());
      if (ins_valid && ins_ready && sb_pc_q.size() > 0) begin
        logic [31:0] exp_pc;
        exp_pc = sb_pc_q.pop_front();
        checkOutput("ins_head", {ins_data, ins_pc, ins_pc4}, {exp_pc ^ MASK, exp_pc, exp_pc + 32'd4});
      end
      if (redir_valid) begin
        if (imem_req)
          discard_pending = 1'b1;
        sb_pc_q.delete();
        exp_next_addr = tb_target;
      end
      if (imem_req) begin
        if (wait_cnt >= mem_waits) begin
          imem_ack = 1'b1;
          imem_rdata = imem_addr ^ MASK;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
      end
      prev_req = imem_req;
      prev_ack = imem_ack;
      prev_addr = imem_addr;
    end
  end

  task automatic checkResetValues(input string name);
    checkOutput({name, "_imem"}, {imem_req, imem_addr, q_count, misalign, ins_valid},
                {1'b0, RESET_PC, 3'd0, 1'b0, 1'b0});
    checkOutput({name, "_head"}, {ins_data, ins_pc, ins_pc4}, 96'h0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    redir_valid = 1'b0;
    ins_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ack_count = 0;
  endtask

  // Drives a one-cycle redirect; returns just after the edge that samples it.
  task automatic applyStimulus(input redir_vec_t v);
    @(posedge clk);
    #1;
    redir_mode = v.mode;
    redir_pc = v.pc;
    redir_imm = v.imm;
    redir_reg = v.rreg;
    tb_target = v.target;
    redir_valid = 1'b1;
    @(posedge clk);
    #1;
    redir_valid = 1'b0;
  endtask

  initial begin
    redir_vec_t slow_vec;
    int guard;
    vecs[0] = '{2'b00, 32'h0000_0100, 26'h000FFFC, 32'h0, 32'h0000_00F4, 1'b0};
    vecs[1] = '{2'b01, 32'hF000_0010, 26'h0000040, 32'h0, 32'hF000_0100, 1'b0};
    vecs[2] = '{2'b10, 32'h0000_0010, 26'h0,       32'h0000_0203, 32'h0000_0200, 1'b1};
    vecs[3] = '{2'b11, 32'h0000_0080, 26'h0,       32'h0, 32'h0000_0084, 1'b0};
    vecs[4] = '{2'b00, 32'h0000_0200, 26'h0000010, 32'h0, 32'h0000_0244, 1'b0};
    vecs[5] = '{2'b10, 32'h0000_0040, 26'h0,       32'h0000_1000, 32'h0000_1000, 1'b0};
    vecs[6] = '{2'b00, 32'hFFFF_FFF8, 26'h0000001, 32'h0, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'b01, 32'h0FFF_FFFC, 26'h3FFFFFF, 32'h0, 32'h1FFF_FFFC, 1'b0};
    slow_vec = '{2'b01, 32'h0, 26'h00000C0, 32'h0, 32'h0000_0300, 1'b0};

    reset = 1'b1;
    redir_valid = 1'b0;
    redir_mode = 2'b00;
    redir_pc = '0;
    redir_imm = '0;
    redir_reg = '0;
    ins_ready = 1'b0;
    tb_target = '0;
    mem_waits = 0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("rst_initial");
    ins_ready = 1'b1;
    reset = 1'b0;
    checkOutput("req_before_first_edge", imem_req, 1'b0);

    // Zero-wait streaming: one fetch per cycle, heads one cycle behind.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("seq_addr", {imem_req, imem_addr}, {1'b1, 32'(4 * i)});
      if (i > 0)
        checkOutput("seq_head", {ins_valid, ins_pc, ins_pc4}, {1'b1, 32'(4 * (i - 1)), 32'(4 * i)});
    end

    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k]);
      checkOutput("redir_addr", {imem_req, imem_addr}, {1'b1, vecs[k].target});
      checkOutput("redir_flush", {q_count, ins_valid}, {3'd0, 1'b0});
      checkOutput("redir_misalign", misalign, vecs[k].mis);
      @(posedge clk);
      #1;
      checkOutput("misalign_pulse_end", misalign, 1'b0);
      repeat (3) @(posedge clk);
    end

    // Decode stalled: queue fills to DEPTH, then drains in order once released.
    doReset();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("full_acks", ack_count, 32'(DEPTH));
    checkOutput("full_state", {imem_req, q_count, ins_valid, ins_pc}, {1'b0, 3'd4, 1'b1, 32'h0});
    ins_ready = 1'b1;
    repeat (12) @(posedge clk);

    // Redirect during a 3-wait-state fetch of 0x40: that data must be dropped.
    doReset();
    mem_waits = 3;
    ins_ready = 1'b1;
    guard = 0;
    while (!(imem_req && imem_addr == 32'h40) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("slow_reach_0x40", {imem_req, imem_addr}, {1'b1, 32'h40});
    applyStimulus(slow_vec);
    guard = 0;
    while (!(imem_req && imem_addr == 32'h300) && guard < 10) begin
      checkOutput("slow_drop_empty", q_count, 3'd0);
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("slow_target_req", {imem_req, imem_addr}, {1'b1, 32'h300});
    guard = 0;
    while (!ins_valid && guard < 10) begin
      checkOutput("slow_wait_empty", q_count, 3'd0);
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("slow_head", {ins_valid, ins_data, ins_pc}, {1'b1, 32'h300 ^ MASK, 32'h300});
    repeat (6) @(posedge clk);

    // Reset asserted mid-handshake with three entries queued.
    doReset();
    mem_waits = 0;
    guard = 0;
    while (!(q_count == 3'd3 && imem_req) && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("pre_reset_state", {q_count, imem_req}, {3'd3, 1'b1});
    reset = 1'b1;
    #1;
    checkResetValues("rst_mid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_release_idle", imem_req, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_resume", {imem_req, imem_addr}, {1'b1, RESET_PC});
    ins_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
